// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: frame state encoding and line levels, common to the
// transmitter and the receiver.
package uartUtil;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        STOP  = 2'd3
    } states_t;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Serial line level for a given frame state; SEND drives the current data bit.
    function automatic logic line_level(input logic [1:0] st, input logic data_bit);
        logic lvl;
        lvl = IDLE_LEVEL;
        if (st == START)
            lvl = START_LEVEL;
        else if (st == SEND)
            lvl = data_bit;
        return lvl;
    endfunction

endpackage

// File: rtl/uart_transmitter_baud_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// clock of each serial bit.
module uart_baud_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bitTick
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] bitTimer;

    assign bitTick = enable && (bitTimer == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bitTimer <= '0;
        else if (clear)
            bitTimer <= '0;
        else if (enable)
            bitTimer <= bitTick ? '0 : bitTimer + TW'(1);
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, STOP_BITS stop bits.
// A 1-entry holding register lets the next byte queue up for gap-free frames.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte in the holding register
//   START | driving the start bit (low) for one bit period
//   SEND  | driving shift_reg[0], shifting after each bit period, 8 bits
//   STOP  | driving stop bit(s) high; reloads straight into START if a byte waits
module uart_transmitter
    import uartUtil::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       txOut,
    output logic       busy,
    output logic       txDone
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_SEND  = SEND;
    localparam logic [1:0] S_STOP  = STOP;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] hold_data;
    logic       hold_full;
    logic       hold_full_next;
    logic [7:0] shift_reg;
    logic [2:0] bit_index;
    logic       stop_index;
    logic       bitTick;
    logic       accept;
    logic       stop_last;
    logic       reload;

    uart_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_IDLE),
        .enable  (state != S_IDLE),
        .bitTick (bitTick)
    );

    assign accept    = txValid && txReady;
    assign stop_last = (state == S_STOP) && bitTick && (stop_index == 1'(STOP_BITS - 1));
    // Holding register drains into the shifter from IDLE or on the final stop clock.
    assign reload         = hold_full && ((state == S_IDLE) || stop_last);
    assign hold_full_next = accept || (hold_full && !reload);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (hold_full) state_next = S_START;
            S_START: if (bitTick) state_next = S_SEND;
            S_SEND:  if (bitTick && (bit_index == 3'd7)) state_next = S_STOP;
            S_STOP:  if (stop_last) state_next = hold_full ? S_START : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            hold_full  <= 1'b0;
            hold_data  <= 8'h00;
            txReady    <= 1'b0;
            shift_reg  <= 8'h00;
            bit_index  <= 3'd0;
            stop_index <= 1'b0;
        end else begin
            state     <= state_next;
            hold_full <= hold_full_next;
            txReady   <= !hold_full_next;
            if (accept)
                hold_data <= txData;
            if (reload)
                shift_reg <= hold_data;
            else if ((state == S_SEND) && bitTick)
                shift_reg <= shift_reg >> 1;
            // bit_index wraps 7 -> 0 on its own as the frame leaves SEND
            if ((state == S_SEND) && bitTick)
                bit_index <= bit_index + 3'd1;
            if ((state == S_STOP) && bitTick)
                stop_index <= stop_last ? 1'b0 : stop_index + 1'b1;
        end
    end

    assign txOut  = line_level(state, shift_reg[0]);
    assign busy   = (state != S_IDLE);
    assign txDone = stop_last;

endmodule
